divider_recon: RTL and testbench

Iterative shift-add reconstruction unit that performs the inverse of the pipelined constant divider: it takes a (quotient, divisor, remainder) triple and rebuilds the dividend as quotient × divisor + remainder. One quotient bit is consumed per clock, so a result is produced SERIES cycles after acceptance. The unit sits on the divider's output side as an in-system self-check and feeds downstream logic through a valid/ready handshake.

---
 rtl/divider_recon.sv | 170 +++++++++++++++++
 tb/tb_divider_recon.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_recon.sv
// rtl/divider_recon.sv - iterative shift-add rebuild of dividend = quotient * divisor + remainder
//
// Takes a (quotient, divisor, remainder) triple from the constant divider and
// rebuilds the dividend, one quotient bit per clock, SERIES cycles per result.
//
// Optional feature macro: DIVIDER_RECON_CHECK_EN
//   defined     : match=1 in DONE when dividend == DIVIDEND and remainder < divisor
//   not defined : match tied to 0, no comparison registers
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous reset, active-high
//   in_valid   input triple valid
//   in_ready   unit can accept a triple (IDLE only)
//   merchant   quotient [SERIES-1:0]
//   divisor    divisor [M-1:0]
//   remainder  remainder [M-1:0]
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   dividend   reconstructed dividend [P-1:0], registered
//   match      self-check flag, registered
module divider_recon #(
  parameter int            N        = 6,
  parameter int            M        = 4,
  parameter int            SERIES   = 5,
  parameter logic [N-1:0]  DIVIDEND = {N{1'b1}},
  localparam int           P        = SERIES + M + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SERIES-1:0] merchant,
  input  logic [M-1:0]      divisor,
  input  logic [M-1:0]      remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [P-1:0]      dividend,
  output logic              match
);

  localparam int                CNT_W    = (SERIES > 1) ? $clog2(SERIES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SERIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [P-1:0]      acc;
  logic [P-1:0]      mcand;
  logic [P-1:0]      acc_sum;
  logic [SERIES-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              load;
  logic              last;

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Partial-product accumulate for the current quotient bit; the maximum
  // possible sum fits in P bits, so no carry out is lost.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // Shift-add datapath
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{(P-M){1'b0}}, remainder};
      mcand  <= {{(P-M){1'b0}}, divisor};
      mplier <= merchant;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result register: captured on the last CALC cycle so it is stable for the
  // whole of DONE, and kept afterwards until the next result lands.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      dividend <= '0;
    end else if (last) begin
      dividend <= acc_sum;
    end
  end

`ifdef DIVIDER_RECON_CHECK_EN
  logic [M-1:0] rem_q;
  logic [M-1:0] div_q;
  logic         match_nxt;

  // The upstream operands are only guaranteed until acceptance, so the
  // remainder/divisor pair is kept locally for the final comparison.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rem_q <= '0;
      div_q <= '0;
    end else if (load) begin
      rem_q <= remainder;
      div_q <= divisor;
    end
  end

  assign match_nxt = (acc_sum == P'(DIVIDEND)) && (rem_q < div_q);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      match <= 1'b0;
    end else if (last) begin
      match <= match_nxt;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^DIVIDEND;
  assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_divider_recon.sv
// tb/tb_divider_recon.sv - scoreboard bench for divider_recon
module tb_divider_recon;

  localparam int SERIES = 5;
  localparam int M      = 4;
  localparam int P      = SERIES + M + 1;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic [SERIES-1:0] merchant;
  logic [M-1:0]      divisor;
  logic [M-1:0]      remainder;
  logic              out_valid;
  logic              out_ready;
  logic [P-1:0]      dividend;
  logic              match;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [P-1:0] d;
    logic         m;
  } exp_t;

  exp_t exp_q[$];

  divider_recon dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .merchant  (merchant),
    .divisor   (divisor),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .match     (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int q, input int d, input int r);
    exp_t e;
    int   v;
    v   = q * d + r;
    e.d = P'(v);
`ifdef DIVIDER_RECON_CHECK_EN
    e.m = (v == 63) && (r < d);
`else
    e.m = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: compare each result at the sample point before its handshake edge
  always @(negedge clk) begin
    if (!rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dividend", dividend, e.d);
        check("match", match, e.m);
      end
    end
  end

  // Drive a triple and return #1 after the edge at which it was accepted
  task automatic send(input int q, input int d, input int r);
    int t;
    @(negedge clk);
    merchant  = SERIES'(q);
    divisor   = M'(d);
    remainder = M'(r);
    in_valid  = 1'b1;
    exp_q.push_back(model(q, d, r));
    t = 0;
    while (!in_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_one(input int q, input int d, input int r);
    int lat;
    send(q, d, r);
    check("in_ready_busy", in_ready, 32'd0);
    wait_out_valid(lat);
    check("latency", lat, SERIES);
    @(posedge clk);
    #1;
    check("out_valid_drop", out_valid, 32'd0);
    check("in_ready_back", in_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rstn      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    merchant  = '0;
    divisor   = '0;
    remainder = '0;
    #1;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_dividend", dividend, 32'd0);
    check("rst_match", match, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;

    // Directed cases
    run_one(21, 3, 0);
    run_one(31, 2, 1);
    run_one(0, 9, 5);
    run_one(31, 15, 15);
    run_one(31, 0, 15);
    run_one(20, 3, 3);

    // Backpressure: hold DONE for 3 cycles, poke a second request meanwhile
    out_ready = 1'b0;
    send(31, 15, 15);
    wait_out_valid(lat);
    check("bp_latency", lat, SERIES);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 32'd1);
      check("bp_dividend", dividend, 32'd480);
      check("bp_in_ready", in_ready, 32'd0);
      if (i == 0) begin
        merchant  = 5'd1;
        divisor   = 4'd1;
        remainder = 4'd0;
        in_valid  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 32'd0);
    check("bp_release_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    check("bp_ignored_ready", in_ready, 32'd1);
    check("bp_ignored_valid", out_valid, 32'd0);

    // Abort during CALC with cnt=2
    send(21, 3, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 32'd0);
    check("abort_dividend", dividend, 32'd0);
    check("abort_in_ready", in_ready, 32'd1);
    check("abort_match", match, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    run_one(21, 3, 0);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      run_one(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
